sc_stream_sequencer: RTL and testbench
======================================

// Module: sc_stream_sequencer
// PURPOSE
//  Sequences one stochastic-computing multiply: reseeds two 16-bit LFSR number generators,
//  runs them for a programmed stream length, and compares each LFSR value to its operand to
//  form two bitstreams. It ANDs the two streams and counts the ones. Sits between the sweep
//  harness (start/done) and the SC datapath, and exposes the raw stream bits for observation.
// PARAMETERS
//  SEED_A   16'hAAAA  reseed value for generator A (nonzero)
//  SEED_B   16'h9999  reseed value for generator B (nonzero)
//  W        16        width of operands, length, LFSR and count (only W=16 supported)
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst        in   1   reset, synchronous, active-high
//  start      in   1   request a run; sampled only in IDLE
//  abort      in   1   cancel a run; returns to IDLE, no done pulse
//  len        in   16  stream length in cycles; latched on accepted start
//  prob_a     in   16  operand A probability code; latched on accepted start
//  prob_b     in   16  operand B probability code; latched on accepted start
//  busy       out  1   high in LOAD and RUN
//  bit_valid  out  1   high in each RUN cycle
//  bit_a      out  1   stream A bit for the current RUN cycle
//  bit_b      out  1   stream B bit for the current RUN cycle
//  done       out  1   one-cycle pulse when the run completes
//  result     out  16  count of cycles with (bit_a & bit_b); valid from done until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE. busy=0, bit_valid=0, bit_a=0, bit_b=0, done=0, result=0.
//         LFSR_A=SEED_A, LFSR_B=SEED_B, internal ones/cycle counters=0.
//  LFSR step (Galois): fb=q[15]. q[0]<=fb. q[i]<=q[i-1] for i in 1..3,7..15.
//         q[i]<=q[i-1]^fb for i=4,5,6. A nonzero seed never reaches 0.
//  Stream bit: bit_x = (LFSR_x <= prob_x_q), unsigned compare on the current LFSR state.
//         prob=0xFFFF gives all ones. prob=0x0000 gives all zeros.
//  FSM:
//   IDLE -> LOAD when start=1. Latch len/prob_a/prob_b. Clear result and counters.
//   LOAD (1 cycle): reseed both LFSRs to SEED_A/SEED_B. Go to RUN if len!=0, else DONE.
//   RUN: bit_valid=1. ones += bit_a&bit_b. Both LFSRs step. cyc += 1.
//        After len RUN cycles, go to DONE with result <= final ones.
//   DONE (1 cycle): done=1, busy=0, then go to IDLE.
//  Latency: start accepted in cycle t -> LOAD at t+1 -> RUN at t+2..t+1+len -> done at t+2+len.
//         len=0 gives done at t+2.
//  Counter width: ones<=len<=65535, so no overflow. Counters are 16 bits, with no wrap.
//  start outside IDLE (including DONE): ignored. No queueing.
//  abort in LOAD/RUN: next state IDLE. done stays 0, result holds the partial count,
//         LFSRs freeze. abort in IDLE/DONE: no effect.
//  abort and start in the same IDLE cycle: start wins (abort has no effect in IDLE).
//  rst mid-run: overrides everything and restores reset values next edge.
//  LFSRs step only in RUN. They hold in IDLE/LOAD/DONE (LOAD writes the seed).
// STRUCTURE
//  Package sc_pkg: typedef enum {IDLE,LOAD,RUN,DONE} sc_state_t.
//         Localparams SC_W=16 and SC_TAP_MASK=16'h0070 (XOR taps at bits 4,5,6).
//  Sub-module sc_sng: one LFSR plus comparator. Ports clk, rst, seed, load, step, prob, bit_o.
//         Instantiated twice with SEED_A/SEED_B.
//  Top: FSM, operand/len latches, cycle counter, ones counter, output registers.
// TESTING
//  1. rst held 2 cycles, then released -> all outputs 0, LFSR_A=0xAAAA, LFSR_B=0x9999, busy=0.
//  2. start, len=0 -> busy for 1 cycle, done at t+2, result=0, bit_valid never asserted.
//  3. start, len=100, prob_a=prob_b=0xFFFF -> 100 bit_valid cycles, done at t+102, result=100.
//  4. start, len=1000, prob_a=0x8000, prob_b=0xFFFF -> result equals golden-model count
//         of LFSR_A<=0x8000 over 1000 steps from 0xAAAA.
//  5. start, len=50, abort at RUN cycle 10 -> IDLE next cycle, no done, result=partial.
//         A fresh start then reproduces the golden result (reseeded).
//  6. start pulsed during RUN and during DONE -> ignored. rst asserted at RUN cycle 5
//         -> reset values next cycle, no done.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing stream sequencer.
//   sc_state_t  : sequencer FSM states
//   SC_W        : datapath width (operands, length, LFSR, counters)
//   SC_TAP_MASK : Galois XOR taps applied when the LFSR MSB shifts out
//   lfsr_next   : one Galois LFSR step
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sc_state_t;

  localparam int unsigned       SC_W        = 16;
  localparam logic [SC_W-1:0]   SC_TAP_MASK = 16'h0070;

  // Shift left, feed MSB into bit 0 and XOR it into the tap positions.
  function automatic logic [SC_W-1:0] lfsr_next(input logic [SC_W-1:0] q);
    return {q[SC_W-2:0], q[SC_W-1]} ^ (q[SC_W-1] ? SC_TAP_MASK : '0);
  endfunction

endpackage

// File: rtl/sc_sng.sv
// Stochastic number generator: one 16-bit Galois LFSR plus a comparator.
//   clk, rst : clock, synchronous active-high reset (LFSR <= seed)
//   seed     : reseed value (nonzero)
//   load     : reseed the LFSR this cycle
//   step     : advance the LFSR one step this cycle
//   prob     : probability code; bit_o = (lfsr <= prob)
//   bit_o    : stream bit for the current LFSR state
module sc_sng
  import sc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [SC_W-1:0] seed,
  input  logic            load,
  input  logic            step,
  input  logic [SC_W-1:0] prob,
  output logic            bit_o
);

  logic [SC_W-1:0] lfsr_q;
  logic [SC_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = (lfsr_q <= prob);

endmodule

// File: rtl/sc_stream_sequencer.sv
// Sequences one stochastic-computing multiply: reseeds two LFSR generators,
// runs them for len cycles, ANDs the two comparator streams and counts ones.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a run (sampled only in IDLE)
//   abort             : cancel a run in LOAD/RUN, no done pulse
//   len, prob_a/b     : stream length and operand codes, latched on start
//   busy              : high in LOAD and RUN
//   bit_valid         : high in each RUN cycle
//   bit_a, bit_b      : stream bits for the current RUN cycle
//   done              : one-cycle completion pulse
//   result            : count of cycles with bit_a & bit_b
module sc_stream_sequencer
  import sc_pkg::*;
#(
  parameter logic [15:0] SEED_A = 16'hAAAA,
  parameter logic [15:0] SEED_B = 16'h9999,
  parameter int unsigned W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] len,
  input  logic [W-1:0] prob_a,
  input  logic [W-1:0] prob_b,
  output logic         busy,
  output logic         bit_valid,
  output logic         bit_a,
  output logic         bit_b,
  output logic         done,
  output logic [W-1:0] result
);

  sc_state_t    state_q, state_d;
  logic [W-1:0] len_q, prob_a_q, prob_b_q;
  logic [W-1:0] cyc_q, ones_q, result_q;
  logic [W-1:0] ones_nxt;
  logic         sng_a, sng_b;
  logic         in_run, in_load, last_cyc, both;

  assign in_run   = (state_q == RUN);
  assign in_load  = (state_q == LOAD);
  // len_q is nonzero whenever RUN is entered, so len_q-1 cannot underflow here.
  assign last_cyc = (cyc_q == len_q - W'(1));
  assign both     = sng_a & sng_b;
  assign ones_nxt = ones_q + W'(both);

  sc_sng u_sng_a (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED_A),
    .load (in_load),
    .step (in_run & ~abort),
    .prob (prob_a_q),
    .bit_o(sng_a)
  );

  sc_sng u_sng_b (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED_B),
    .load (in_load),
    .step (in_run & ~abort),
    .prob (prob_b_q),
    .bit_o(sng_b)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (abort)            state_d = IDLE;
        else if (len_q != '0) state_d = RUN;
        else                  state_d = DONE;
      end
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (last_cyc) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = in_load | in_run;
    bit_valid = in_run;
    bit_a     = in_run & sng_a;
    bit_b     = in_run & sng_b;
    done      = (state_q == DONE);
  end

  // Operand latches and counters; an aborted RUN cycle still counts its bit
  // so result reflects every cycle that was presented with bit_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      prob_a_q <= '0;
      prob_b_q <= '0;
      cyc_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            prob_a_q <= prob_a;
            prob_b_q <= prob_b;
            cyc_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          ones_q <= ones_nxt;
          cyc_q  <= cyc_q + W'(1);
          if (abort || last_cyc) begin
            result_q <= ones_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
module tb_sc_stream_sequencer;

  localparam logic [15:0] SA = 16'hAAAA;
  localparam logic [15:0] SB = 16'h9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] len = '0;
  logic [15:0] prob_a = '0;
  logic [15:0] prob_b = '0;
  logic        busy, bit_valid, bit_a, bit_b, done;
  logic [15:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [1:0]  bitq[$];
  logic [15:0] resq[$];

  always #5 clk = ~clk;

  sc_stream_sequencer #(
    .SEED_A(SA),
    .SEED_B(SB),
    .W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .len      (len),
    .prob_a   (prob_a),
    .prob_b   (prob_b),
    .busy     (busy),
    .bit_valid(bit_valid),
    .bit_a    (bit_a),
    .bit_b    (bit_b),
    .done     (done),
    .result   (result)
  );

  // Reference Galois step written bit by bit.
  function automatic logic [15:0] m_step(input logic [15:0] q);
    logic [15:0] n;
    logic fb;
    fb = q[15];
    n[0] = fb;
    for (int i = 1; i < 16; i++) begin
      n[i] = q[i-1] ^ (((i >= 4) && (i <= 6)) ? fb : 1'b0);
    end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, bit_valid, bit_a, bit_b, done} !== 5'b0 || result !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b bv=%b a=%b b=%b done=%b result=%0d, want all 0",
               busy, bit_valid, bit_a, bit_b, done, result);
    end
    n_cmp++;
    if (dut.u_sng_a.lfsr_q !== SA || dut.u_sng_b.lfsr_q !== SB) begin
      n_bad++;
      $display("FAIL reset_lfsr: got A=%h B=%h, want A=%h B=%h",
               dut.u_sng_a.lfsr_q, dut.u_sng_b.lfsr_q, SA, SB);
    end
  endtask

  // Generic run: abort_at / rst_at give the 1-based RUN cycle (0 = none);
  // poke drives start during RUN cycle 3 and during DONE.
  task automatic do_run(input string name, input int unsigned len_v,
                        input logic [15:0] pa, input logic [15:0] pb,
                        input int unsigned abort_at, input int unsigned rst_at,
                        input bit poke, input bit abort_with_start);
    logic [15:0] la, lb, er;
    logic [1:0]  eb;
    int unsigned tot, rc, exp_ones;
    bit          fin, ok_done;
    la = SA; lb = SB; tot = 0;
    for (int unsigned i = 0; i < len_v; i++) begin
      eb = {la <= pa, lb <= pb};
      bitq.push_back(eb);
      tot += int'(eb[1] & eb[0]);
      la = m_step(la);
      lb = m_step(lb);
    end
    if (abort_at == 0 && rst_at == 0) resq.push_back(tot[15:0]);

    @(negedge clk);
    start = 1'b1; abort = abort_with_start;
    len = len_v[15:0]; prob_a = pa; prob_b = pb;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || bit_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_load: got busy=%b bv=%b done=%b, want 1 0 0", name, busy, bit_valid, done);
    end

    rc = 0; exp_ones = 0; fin = 0; ok_done = 0; er = '0;
    for (int unsigned cyc = 1; cyc <= len_v + 8 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (bit_valid === 1'b1) begin
        rc++;
        eb = (bitq.size() > 0) ? bitq.pop_front() : 2'bxx;
        exp_ones += int'(eb[1] & eb[0]);
        n_cmp++;
        if ({bit_a, bit_b} !== eb || busy !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_bits@%0d: got a=%b b=%b busy=%b done=%b, want a=%b b=%b busy=1 done=0",
                   name, rc, bit_a, bit_b, busy, done, eb[1], eb[0]);
        end
        if (rc == abort_at) abort = 1'b1;
        if (rc == rst_at) rst = 1'b1;
        if (poke && rc == 3) begin start = 1'b1; len = 16'd7; end
      end else if (done === 1'b1) begin
        fin = 1; ok_done = 1;
        er = (resq.size() > 0) ? resq.pop_front() : 16'hxxxx;
        n_cmp++;
        if (cyc != len_v + 1 || rc != len_v || busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_timing: done at cycle %0d after %0d RUN cycles busy=%b, want cycle %0d, %0d cycles, busy=0",
                   name, cyc, rc, busy, len_v + 1, len_v);
        end
        n_cmp++;
        if (result !== er) begin
          n_bad++;
          $display("FAIL %s_result: got %0d, want %0d", name, result, er);
        end
        if (poke) start = 1'b1;
      end else begin
        fin = 1;
        if (rst === 1'b1) begin
          rst = 1'b0;
          n_cmp++;
          if ({busy, bit_valid, bit_a, bit_b, done} !== 5'b0 || result !== 16'd0 ||
              dut.u_sng_a.lfsr_q !== SA || dut.u_sng_b.lfsr_q !== SB) begin
            n_bad++;
            $display("FAIL %s_midrst: got busy=%b bv=%b done=%b result=%0d A=%h B=%h, want 0 0 0 0 %h %h",
                     name, busy, bit_valid, done, result, dut.u_sng_a.lfsr_q, dut.u_sng_b.lfsr_q, SA, SB);
          end
        end else if (abort_at != 0 && rc == abort_at) begin
          n_cmp++;
          if (busy !== 1'b0 || done !== 1'b0 || result !== exp_ones[15:0]) begin
            n_bad++;
            $display("FAIL %s_abort: got busy=%b done=%b result=%0d, want 0 0 %0d",
                     name, busy, done, result, exp_ones);
          end
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL %s_early_idle: left run after %0d RUN cycles, want %0d", name, rc, len_v);
        end
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, len_v + 8);
    end
    bitq.delete();
    resq.delete();

    if (ok_done) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== er) begin
        n_bad++;
        $display("FAIL %s_hold: got busy=%b done=%b result=%0d, want 0 0 %0d", name, busy, done, result, er);
      end
      if (poke) begin
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_start_in_done: got busy=%b, want 0", name, busy);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_zero();
    do_run("len0", 0, 16'h1234, 16'h4321, 0, 0, 0, 0);
  endtask

  task automatic test_start_abort_idle();
    do_run("start_abort", 3, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1);
  endtask

  task automatic test_all_ones();
    do_run("ones100", 100, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
  endtask

  task automatic test_zero_prob();
    do_run("zero40", 40, 16'h0000, 16'hFFFF, 0, 0, 0, 0);
  endtask

  task automatic test_golden();
    do_run("golden1000", 1000, 16'h8000, 16'hFFFF, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    do_run("abort", 50, 16'h8000, 16'hC000, 10, 0, 0, 0);
    do_run("after_abort", 50, 16'h8000, 16'hC000, 0, 0, 0, 0);
  endtask

  task automatic test_ignored_start();
    do_run("poke", 20, 16'h6000, 16'hA000, 0, 0, 1, 0);
  endtask

  task automatic test_rst_mid_run();
    do_run("midrst", 30, 16'h7FFF, 16'h9000, 0, 5, 0, 0);
    do_run("after_rst", 30, 16'h7FFF, 16'h9000, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_run("b2b_1", 17, 16'h4000, 16'hE000, 0, 0, 0, 0);
    do_run("b2b_2", 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_start_abort_idle();
    test_all_ones();
    test_zero_prob();
    test_golden();
    test_abort();
    test_ignored_start();
    test_rst_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
